// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
//   Pipelined two's-complement adder/subtractor. The WIDTH-bit carry chain is cut
//   into STAGES equal slices; slice k is added in stage k using the carry that
//   stage k-1 registered. Inside a slice, carries come from 4-bit-group
//   carry-lookahead logic. All stages advance together under a valid/ready
//   handshake. The final stage produces saturation, NZVC flags and a sticky
//   overflow bit.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready = ~out_valid | out_ready
//   a, b                WIDTH-bit two's-complement operands
//   sub                 1: a - b, 0: a + b
//   sat_en              clamp signed overflow to the max/min representable value
//   out_valid/out_ready result handshake
//   result              sum/difference, saturated when sat_en and V
//   cout                carry out of the MSB (for sub, 1 = no borrow)
//   N, Z                sign and zero of the final (post-saturation) result
//   V                   signed overflow of the unsaturated operation
//   sticky_v            set by any delivered result with V=1
//   clr_sticky          synchronous clear of sticky_v (a same-cycle set wins)
// -----------------------------------------------------------------------------
module cla_addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             sticky_v,
    input  logic             clr_sticky
);

    localparam int SL = WIDTH / STAGES;

    if (WIDTH < 4 || STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("cla_addsub_pipe: WIDTH must be >= 4, STAGES 1..4, and WIDTH divisible by STAGES");
    end

    // One slice of carry-lookahead addition. Bits are grouped by four; each
    // carry within a group is expanded directly from the group's generate and
    // propagate terms and the group carry-in, so no carry ripples bit to bit
    // inside a group. Returns {carry_out, sum}.
    function automatic logic [SL:0] cla_slice(input logic [SL-1:0] x,
                                              input logic [SL-1:0] y,
                                              input logic          cin);
        logic [SL-1:0] g;
        logic [SL-1:0] p;
        logic [SL:0]   c;
        logic          term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int base = 0; base < SL; base += 4) begin
            for (int j = base; j < base + 4 && j < SL; j++) begin
                term = c[base];
                for (int m = base; m <= j; m++) term = term & p[m];
                c[j+1] = term;
                for (int m = base; m <= j; m++) begin
                    term = g[m];
                    for (int n = m + 1; n <= j; n++) term = term & p[n];
                    c[j+1] = c[j+1] | term;
                end
            end
        end
        return {c[SL], p ^ c[SL-1:0]};
    endfunction

    // Stage k registers. Operands travel in full so the upper slices are
    // delay-matched; raw_q[k] holds every result slice finished so far.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q,   c_d;
    logic [STAGES-1:0] sat_q, sat_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  bp_q  [STAGES];
    logic [WIDTH-1:0]  bp_d  [STAGES];
    logic [WIDTH-1:0]  raw_q [STAGES];
    logic [WIDTH-1:0]  raw_d [STAGES];

    // Values entering stage k: the ports for stage 0, stage k-1 registers otherwise.
    logic [STAGES-1:0] s_vld, s_c, s_sat;
    logic [WIDTH-1:0]  s_a   [STAGES];
    logic [WIDTH-1:0]  s_bp  [STAGES];
    logic [WIDTH-1:0]  s_raw [STAGES];
    logic [SL:0]       slice_sum;

    logic              advance;
    logic              sticky_q, sticky_d;
    logic [WIDTH-1:0]  fin_raw;
    logic              a_msb, bp_msb, ovf;

    // NOTE: every signal written here gets a value before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        advance   = ~vld_q[STAGES-1] | out_ready;
        slice_sum = '0;

        s_vld[0] = in_valid;
        s_a[0]   = a;
        s_bp[0]  = sub ? ~b : b;
        s_raw[0] = '0;
        s_c[0]   = sub;       // carry-in of 1 completes ~b + 1 for subtraction
        s_sat[0] = sat_en;
        for (int k = 1; k < STAGES; k++) begin
            s_vld[k] = vld_q[k-1];
            s_a[k]   = a_q[k-1];
            s_bp[k]  = bp_q[k-1];
            s_raw[k] = raw_q[k-1];
            s_c[k]   = c_q[k-1];
            s_sat[k] = sat_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            slice_sum             = cla_slice(s_a[k][k*SL +: SL], s_bp[k][k*SL +: SL], s_c[k]);
            raw_d[k]              = s_raw[k];
            raw_d[k][k*SL +: SL]  = slice_sum[SL-1:0];
            c_d[k]                = slice_sum[SL];
            a_d[k]                = s_a[k];
            bp_d[k]               = s_bp[k];
            sat_d[k]              = s_sat[k];
            vld_d[k]              = s_vld[k];
        end
    end

    // NOTE: state updates use non-blocking assignments so every stage samples
    // the pre-edge value of the stage before it, regardless of statement order.
    // NOTE: the datapath registers are reset along with the valid bits so that
    // result and the flags read 0 during and right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            sat_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bp_q[k]  <= '0;
                raw_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            sat_q <= sat_d;
            a_q   <= a_d;
            bp_q  <= bp_d;
            raw_q <= raw_d;
        end
    end

    // Final-stage flags and saturation from the registered raw result.
    always_comb begin
        fin_raw = raw_q[STAGES-1];
        a_msb   = a_q[STAGES-1][WIDTH-1];
        bp_msb  = bp_q[STAGES-1][WIDTH-1];
        ovf     = (a_msb == bp_msb) & (fin_raw[WIDTH-1] != a_msb);
        if (sat_q[STAGES-1] & ovf) begin
            result = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            result = fin_raw;
        end
    end

    // A delivery with overflow beats a simultaneous clear.
    always_comb begin
        sticky_d = sticky_q;
        if (out_valid & out_ready & ovf) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign V         = ovf;
    assign N         = result[WIDTH-1];
    // The all-zero reset image would otherwise look like a zero result.
    assign Z         = out_valid & (result == '0);
    assign sticky_v  = sticky_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_addsub_pipe
//   Scoreboard bench for cla_addsub_pipe (WIDTH=16, STAGES=2). The driver pushes
//   the expected response of each accepted op; a monitor pops and compares on
//   every delivery and watches held outputs during back-pressure.
// -----------------------------------------------------------------------------
module tb_cla_addsub_pipe;

    localparam int W = 16;
    localparam int S = 2;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         in_valid   = 1'b0;
    logic         sub        = 1'b0;
    logic         sat_en     = 1'b0;
    logic         out_ready  = 1'b1;
    logic         clr_sticky = 1'b0;
    logic [W-1:0] a          = '0;
    logic [W-1:0] b          = '0;
    logic         in_ready, out_valid, cout, N, Z, V, sticky_v;
    logic [W-1:0] result;

    cla_addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sub        (sub),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .cout       (cout),
        .N          (N),
        .Z          (Z),
        .V          (V),
        .sticky_v   (sticky_v),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         n;
        logic         z;
        logic         v;
        bit           chk_lat;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact signed/unsigned arithmetic, then wrap or clamp.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic isub, input logic isat,
                                   input bit lat, input int acc);
        exp_t   e;
        longint sa, sb, ex, ua, ub, maxp, minn;
        maxp = (longint'(1) << (W - 1)) - 1;
        minn = -(longint'(1) << (W - 1));
        sa   = longint'($signed(ia));
        sb   = longint'($signed(ib));
        ua   = longint'(ia);
        ub   = longint'(ib);
        ex   = isub ? sa - sb : sa + sb;
        e.v    = (ex > maxp) || (ex < minn);
        e.cout = isub ? (ua >= ub) : ((ua + ub) >= (longint'(1) << W));
        e.res  = (isat && e.v) ? ((ex > 0) ? W'(maxp) : W'(minn)) : W'(ex);
        e.n    = e.res[W-1];
        e.z    = (e.res == '0);
        e.chk_lat = lat;
        e.acc     = acc;
        return e;
    endfunction

    // Call at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic isat, input bit lat);
        int waited = 0;
        a = ia; b = ib; sub = isub; sat_en = isat; in_valid = 1'b1;
        #2;
        while (!in_ready) begin
            @(negedge clk);
            #2;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck low");
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(model(ia, ib, isub, isat, lat, cyc));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_out_valid", 32'(out_valid), 32'd1);
    endtask

    // Monitor: compare on every delivery, check stability while stalled.
    logic [W+3:0] held_val = '0;
    bit           held     = 0;
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (!rst_n) begin
            held = 0;
        end else begin
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                if (held) check("held_outputs", 32'({result, cout, N, Z, V}), 32'(held_val));
                held     = 1;
                held_val = {result, cout, N, Z, V};
            end else begin
                held = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: result %h with nothing outstanding", result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("cout",   32'(cout),   32'(e.cout));
                    check("N",      32'(N),      32'(e.n));
                    check("Z",      32'(Z),      32'(e.z));
                    check("V",      32'(V),      32'(e.v));
                    if (e.chk_lat) check("latency", 32'(cyc - e.acc), 32'(S));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_flags",     32'({cout, N, Z, V}), 32'd0);
        check("rst_sticky",    32'(sticky_v),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases, back to back with out_ready high.
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
        send(16'h8000, 16'h0001, 1'b1, 1'b1, 1);
        send(16'h0005, 16'h0005, 1'b1, 1'b0, 1);
        send(16'h0003, 16'h0005, 1'b1, 1'b0, 1);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1);
        send(16'h8000, 16'h8000, 1'b0, 1'b1, 1);
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1);
        end
        drain();

        // Three-cycle stall in the middle of a four-op stream.
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
                end
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic under random back-pressure.
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Sticky overflow: clear, set, then clear racing a set.
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        #4;
        check("sticky_cleared", 32'(sticky_v), 32'd0);
        @(negedge clk);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1);
        wait_valid();
        @(negedge clk);
        #4;
        check("sticky_set", 32'(sticky_v), 32'd1);
        @(negedge clk);
        send(16'h8000, 16'h0001, 1'b1, 1'b0, 1);
        wait_valid();
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        #4;
        check("sticky_set_wins", 32'(sticky_v), 32'd1);

        // Reset with two ops in flight.
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        send(16'h4000, 16'h4000, 1'b0, 1'b1, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sticky",    32'(sticky_v),  32'd0);
        check("midrst_result",    32'(result),    32'd0);
        exp_q.delete();
        @(negedge clk);
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("no_stale_output", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        send(16'h1000, 16'h0234, 1'b0, 1'b0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
